// File: rtl/nor_bist_ctrl.sv
// nor_bist_ctrl: built-in self-test controller for a two-input NOR cell.
//
// On an accepted start it drives {dut_a, dut_b} through 00, 01, 10, 11 for ITER sweeps.
// Each vector is held for one APPLY cycle, SETTLE_CYCLES settle cycles and one SAMPLE
// cycle. dut_y is compared with the expected NOR value at the edge that ends SAMPLE.
//
// Parameters:
//   SETTLE_CYCLES  settle cycles before sampling dut_y (1..15)
//   ITER           full truth-table sweeps per run (1..255)
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   start, abort   run request (honoured only in IDLE); abort of a run in progress
//   dut_a, dut_b   drive the NOR cell inputs (a is the vector MSB)
//   dut_y          NOR cell output
//   busy           high in APPLY/SETTLE/SAMPLE
//   done           one-cycle pulse at run completion
//   pass           result of the last completed run; cleared on start
//   err_cnt        saturating mismatch count
//   fail_vec       sticky per-vector failure map
// Build option:
//   NOR_BIST_FAILVEC_EN  builds the fail_vec flops; when undefined, fail_vec is tied to 0.

module nor_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ITER          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SweepLast  = 8'(ITER - 1);

    typedef enum logic [2:0] {StIdle, StApply, StSettle, StSample, StDone} state_e;

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] sweep_q, sweep_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic run_active;
    logic accept;
    logic sample_en;
    logic mismatch;

    assign run_active = (state_q == StApply) || (state_q == StSettle) || (state_q == StSample);
    assign accept     = (state_q == StIdle) && start && !abort;
    // abort wins over a compare in the same cycle, so that sample is dropped
    assign sample_en  = (state_q == StSample) && !abort;
    // expected NOR output is 1 only for vector 00
    assign mismatch   = dut_y != (vec_q == 2'd0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            vec_q    <= 2'd0;
            sweep_q  <= 8'd0;
            settle_q <= 4'd0;
            err_q    <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            sweep_q  <= sweep_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start && !abort) state_d = StApply;
            StApply:  state_d = abort ? StIdle : StSettle;
            StSettle: begin
                if (abort)                         state_d = StIdle;
                else if (settle_q == SettleLast)   state_d = StSample;
            end
            StSample: begin
                if (abort)                                         state_d = StIdle;
                else if (vec_q != 2'd3 || sweep_q != SweepLast)    state_d = StApply;
                else                                               state_d = StDone;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath: vector index, sweep and settle counters, mismatch count
    always_comb begin
        vec_d    = vec_q;
        sweep_d  = sweep_q;
        settle_d = settle_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    vec_d   = 2'd0;
                    sweep_d = 8'd0;
                    err_d   = 8'd0;
                end
            end
            StApply:  settle_d = 4'd0;
            StSettle: settle_d = settle_q + 4'd1;
            StSample: begin
                if (sample_en) begin
                    if (mismatch && err_q != 8'hFF) err_d = err_q + 8'd1;
                    // wrapping to 00 also parks the inputs when the run finishes
                    vec_d = vec_q + 2'd1;
                    if (vec_q == 2'd3 && sweep_q != SweepLast) sweep_d = sweep_q + 8'd1;
                end
            end
            default: ;
        endcase
        if (run_active && abort) vec_d = 2'd0;
    end

    // Registered outputs, derived from the next state
    always_comb begin
        busy_d = (state_d == StApply) || (state_d == StSettle) || (state_d == StSample);
        done_d = (state_d == StDone);
        pass_d = pass_q;
        if (accept)              pass_d = 1'b0;
        if (state_d == StDone)   pass_d = (err_d == 8'd0);
    end

    assign dut_a   = vec_q[1];
    assign dut_b   = vec_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

`ifdef NOR_BIST_FAILVEC_EN
    logic [3:0] fail_q, fail_d;

    always_comb begin
        fail_d = fail_q;
        if (accept)                      fail_d = 4'd0;
        else if (sample_en && mismatch)  fail_d[vec_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) fail_q <= 4'd0;
        else        fail_q <= fail_d;
    end

    assign fail_vec = fail_q;
`else
    assign fail_vec = 4'd0;
`endif

endmodule

// File: tb/tb_nor_bist_ctrl.sv
// Directed testbench for nor_bist_ctrl. Three instances share one clock and reset:
//   u_dut0  defaults (SETTLE_CYCLES=2, ITER=1), dut_y from a correct NOR or an OR cell
//   u_dut1  ITER=2, dut_y stuck at 0
//   u_dut2  ITER=100, dut_y stuck at 1 (drives err_cnt into saturation)

module tb_nor_bist_ctrl;

`ifdef NOR_BIST_FAILVEC_EN
    localparam bit FvEn = 1'b1;
`else
    localparam bit FvEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic tie0 = 1'b0;
    logic tie1 = 1'b1;

    logic       start0, abort0, a0, b0, y0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [3:0] fv0;
    logic       mode_or;

    logic       start1, a1, b1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [3:0] fv1;

    logic       start2, a2, b2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [3:0] fv2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign y0 = mode_or ? (a0 | b0) : ~(a0 | b0);

    nor_bist_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
    );

    nor_bist_ctrl #(.SETTLE_CYCLES(2), .ITER(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(tie0),
        .dut_a(a1), .dut_b(b1), .dut_y(tie0),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    nor_bist_ctrl #(.SETTLE_CYCLES(2), .ITER(100)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(tie0),
        .dut_a(a2), .dut_b(b2), .dut_y(tie1),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Pulse start on one instance; cyc = cycle index (from the start edge) where done is seen
    task automatic run_wait(input int which, input int limit, output int cyc);
        cyc = -1;
        start0 = (which == 0);
        start1 = (which == 1);
        start2 = (which == 2);
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        for (int k = 0; k <= limit; k++) begin
            if (done_of(which)) begin
                cyc = k;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int         cyc;
        int         seen_done;
        logic [1:0] exp_ab;

        rst_n   = 1'b0;
        start0  = 1'b0;
        abort0  = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        mode_or = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ab",    {30'd0, a0, b0}, 32'd0);
        check("rst_busy",  busy0, 1'b0);
        check("rst_done",  done0, 1'b0);
        check("rst_pass",  pass0, 1'b0);
        check("rst_err",   err0, 8'd0);
        check("rst_fv",    fv0, 4'd0);
        check("rst_busy1", busy1, 1'b0);
        rst_n = 1'b1;
        tick();

        // Clean run on a correct NOR; start pulses while busy and in DONE are ignored
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 18; k++) begin
            exp_ab = (k < 16) ? 2'(k / 4) : 2'd0;
            check("t1_ab",   {30'd0, a0, b0}, {30'd0, exp_ab});
            check("t1_busy", busy0, (k < 16));
            check("t1_done", done0, (k == 16));
            if (k == 16) begin
                check("t1_pass", pass0, 1'b1);
                check("t1_err",  err0, 8'd0);
                check("t1_fv",   fv0, 4'd0);
            end
            start0 = (k == 2 || k == 9 || k == 15 || k == 16);
            tick();
        end
        start0 = 1'b0;

        // OR cell substituted: every vector mismatches
        mode_or = 1'b1;
        run_wait(0, 40, cyc);
        check("or_done_cyc", cyc, 16);
        check("or_err",  err0, 8'd4);
        check("or_pass", pass0, 1'b0);
        check("or_fv",   fv0, FvEn ? 4'b1111 : 4'b0000);
        tick();

        // Stuck-at-0, two sweeps: only vector 00 fails, once per sweep
        run_wait(1, 60, cyc);
        check("sa0_done_cyc", cyc, 32);
        check("sa0_err",  err1, 8'd2);
        check("sa0_pass", pass1, 1'b0);
        check("sa0_fv",   fv1, FvEn ? 4'b0001 : 4'b0000);
        tick();

        // Abort in SETTLE of vector 2, then a clean rerun
        mode_or = 1'b0;
        start0  = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (9) tick();
        check("ab_vec2",  {30'd0, a0, b0}, 32'd2);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        check("ab_busy", busy0, 1'b0);
        check("ab_ab",   {30'd0, a0, b0}, 32'd0);
        check("ab_done", done0, 1'b0);
        check("ab_pass", pass0, 1'b0);
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            if (done0 || busy0) seen_done++;
            tick();
        end
        check("ab_quiet", seen_done, 0);
        run_wait(0, 40, cyc);
        check("ab_rerun_cyc",  cyc, 16);
        check("ab_rerun_pass", pass0, 1'b1);
        check("ab_rerun_err",  err0, 8'd0);
        tick();

        // start and abort together in IDLE
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        start0 = 1'b0;
        abort0 = 1'b0;
        check("sa_busy", busy0, 1'b0);
        tick();
        check("sa_busy2", busy0, 1'b0);
        check("sa_ab",    {30'd0, a0, b0}, 32'd0);

        // Reset mid-run (OR cell so err_cnt is non-zero beforehand)
        mode_or = 1'b1;
        start0  = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (9) tick();
        check("mr_err_pre", err0, 8'd2);
        rst_n = 1'b0;
        tick();
        check("mr_ab",   {30'd0, a0, b0}, 32'd0);
        check("mr_busy", busy0, 1'b0);
        check("mr_done", done0, 1'b0);
        check("mr_pass", pass0, 1'b0);
        check("mr_err",  err0, 8'd0);
        check("mr_fv",   fv0, 4'd0);
        rst_n   = 1'b1;
        mode_or = 1'b0;
        tick();

        // Saturation: stuck-at-1 over 100 sweeps gives 300 mismatches
        run_wait(2, 1700, cyc);
        check("sat_done_cyc", cyc, 1600);
        check("sat_err",  err2, 8'd255);
        check("sat_pass", pass2, 1'b0);
        check("sat_fv",   fv2, FvEn ? 4'b1110 : 4'b0000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nor_bist_ctrl.md
# nor_bist_ctrl

Built-in self-test controller for the two-input NOR cell. On a start pulse it drives the cell's `a`/`b` inputs through the full truth table (00, 01, 10, 11) for a configurable number of sweeps. After each vector it waits a programmable settle time, samples `y` and compares it against the expected NOR value. It reports a done pulse, pass/fail, a saturating mismatch count and, optionally, a per-vector failure map. The block sits beside the NOR cell and owns its inputs during test.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles between applying a vector and sampling `y`. Legal range is 1..15.
- `ITER`, default 1: number of full truth-table sweeps per run. Legal range is 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  terminates a run in progress.
- `dut_a`  out  1  drives NOR input a (vector MSB).
- `dut_b`  out  1  drives NOR input b (vector LSB).
- `dut_y`  in  1  NOR cell output.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at run completion.
- `pass`  out  1  run result; holds until the next start.
- `err_cnt`  out  8  mismatch count; saturates at 255.
- `fail_vec`  out  4  sticky per-vector failure map (see Configuration).

## Operation
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- **IDLE**
  - `start=1` and `abort=0` → APPLY.
  - On that edge: vector index ← 0, sweep count ← 0, `err_cnt` ← 0, `pass` ← 0, `fail_vec` ← 0.
  - `{dut_a,dut_b}` ← vector 0.
- **APPLY**: one cycle → SETTLE; settle counter ← 0.
- **SETTLE**: counts `SETTLE_CYCLES` cycles → SAMPLE.
- **SAMPLE**
  - Compares `dut_y` with the expected value `~(a|b)`. The expected sequence for vectors 0..3 is 1, 0, 0, 0.
  - On mismatch, `err_cnt` increments; it saturates at 255 and never wraps.
  - Next state:
    - vector < 3: index+1, drive the new vector, → APPLY.
    - vector = 3 and sweep < `ITER`-1: sweep+1, index ← 0, drive 00, → APPLY.
    - Otherwise: → DONE.
- **DONE**: one cycle; `done=1`, `pass` ← (final `err_cnt`==0), `{dut_a,dut_b}` ← 00 → IDLE.
- `busy` = 1 in APPLY, SETTLE and SAMPLE; 0 in IDLE and DONE.
- `abort` in APPLY, SETTLE or SAMPLE:
  - Next state is IDLE and `{dut_a,dut_b}` ← 00.
  - No done pulse; `pass` stays 0.
  - `err_cnt` and `fail_vec` keep their values at the abort.
- Simultaneous events:
  - `abort` has priority over a SAMPLE compare in the same cycle; that sample is discarded.
  - `start` while busy or in DONE is ignored.
  - `start` and `abort` together in IDLE: stays IDLE.
- All outputs are registered.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE; `dut_a`, `dut_b`, `busy`, `done`, `pass` = 0; `err_cnt` = 0; `fail_vec` = 0.
- Reset mid-run takes effect at the next edge and overrides every other input.
- With `start` sampled at edge 0:
  - Vector 0 is on `dut_a`/`dut_b` and `busy`=1 from edge 0.
  - Each vector is held for `SETTLE_CYCLES`+2 cycles. `dut_y` is sampled at the last edge of the SAMPLE cycle.
  - `done` is high during cycle N = 4·`ITER`·(`SETTLE_CYCLES`+2), counting from edge 0.
  - `pass` is valid in that same cycle.
  - Earliest next accepted `start` is in cycle N+1.
- Defaults: 16 busy cycles, `done` in cycle 16.
- The controller assumes the NOR cell's combinational delay is less than `SETTLE_CYCLES` clock periods.

## Configuration
- Macro: `NOR_BIST_FAILVEC_EN`.
- Defined:
  - `fail_vec[i]` is set, and stays set, when vector i mismatches in any sweep.
  - Cleared on accepted `start` and on reset; retained on abort.
- Undefined:
  - `fail_vec` is tied to 4'b0000 and no flops are built.
  - All other behaviour is identical.

## Test plan
- Correct NOR, defaults, `start` pulse at cycle 0:
  - `{a,b}` = 00, 01, 10, 11, each held 4 cycles.
  - `done` in cycle 16, `pass`=1, `err_cnt`=0, `fail_vec`=0000.
- `dut_y` stuck-at-0, `ITER`=2: `err_cnt`=2, `pass`=0, `fail_vec`=4'b0001 (0000 with the macro off).
- OR cell substituted (y=a|b), `ITER`=1: `err_cnt`=4, `pass`=0, `fail_vec`=4'b1111.
- `abort` in the SETTLE state of vector 2 (correct NOR):
  - Next cycle: `busy`=0, `{a,b}`=00, no `done`, `pass`=0.
  - A following `start` completes a clean run with `pass`=1.
- Control and reset corner cases:
  - `start` pulses while busy are ignored; `done` still arrives in cycle 16.
  - `start`+`abort` together in IDLE: `busy` stays 0.
  - `rst_n` low for one cycle mid-run: all outputs 0 at the next edge.
- Saturation: `dut_y` stuck-at-1, `ITER`=100 gives 300 mismatches → `err_cnt`=255 with no wrap, `fail_vec`=4'b1110.
